// File: rtl/aes128_decrypt_iter.sv
// ---------------------------------------------------------------------------
// aes128_decrypt_iter
//   Iterative AES-128 decryption core (FIPS-197 InvCipher). One inverse round
//   per clock on a single 128-bit state register. The key schedule is run
//   forward to rk10 and then walked backward alongside the rounds, so only one
//   round key is ever stored.
//
//   Ports
//     clk        in   1    rising-edge clock
//     rst        in   1    synchronous, active-high reset
//     in_valid   in   1    cipher_in/key_in valid
//     in_ready   out  1    core idle, can accept a block
//     cipher_in  in   128  ciphertext, byte 0 in bits [127:120], column-major
//     key_in     in   128  cipher key (rk10 when KEY_IS_LAST=1), same order
//     out_valid  out  1    plain_out holds a finished block
//     out_ready  in   1    sink accepts plain_out
//     plain_out  out  128  recovered plaintext, same order
//
//   Also contains the shared GF(2^8) helper package and the sbox / inv_sbox
//   submodules used by the core.
// ---------------------------------------------------------------------------

package aes128_gf_pkg;

  // Multiply by x in GF(2^8) modulo 0x11b.
  function automatic logic [7:0] xtime(input logic [7:0] a);
    xtime = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // General GF(2^8) multiply, shift-and-add.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) begin
        p = p ^ aa;
      end else begin
        p = p;
      end
      aa = xtime(aa);
    end
    gf_mul = p;
  endfunction

  // Multiplicative inverse as a^254 (maps 0 to 0, as the S-box requires).
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] x2, x3, x12, x15, x240;
    x2   = gf_mul(a, a);
    x3   = gf_mul(x2, a);
    x12  = gf_mul(gf_mul(x3, x3), gf_mul(x3, x3));
    x15  = gf_mul(x12, x3);
    x240 = gf_mul(x15, x15);
    x240 = gf_mul(x240, x240);
    x240 = gf_mul(x240, x240);
    x240 = gf_mul(x240, x240);
    gf_inv = gf_mul(gf_mul(x240, x12), x2);
  endfunction

endpackage

module aes128_decrypt_iter
  import aes128_gf_pkg::*;
#(
  parameter bit KEY_IS_LAST = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] cipher_in,
  input  logic [127:0] key_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] plain_out
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_KEXP = 3'd1,
    S_DEC  = 3'd2,
    S_FIN  = 3'd3,
    S_HOLD = 3'd4
  } state_e;

  state_e       fsm_q, fsm_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [127:0] key_q, key_d;
  logic [127:0] st_q, st_d;
  logic [127:0] pt_q, pt_d;
  logic         in_ready_q, in_ready_d;
  logic         out_valid_q, out_valid_d;

  // Round constant lookup; unreachable counter values give 00.
  function automatic logic [7:0] rcon(input logic [3:0] idx);
    case (idx)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  endfunction

  // InvMixColumns on all four columns, matrix {0e,0b,0d,09}.
  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = 128'd0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = gf_mul(8'h0e, a0) ^ gf_mul(8'h0b, a1) ^ gf_mul(8'h0d, a2) ^ gf_mul(8'h09, a3);
      o[119-32*c -: 8] = gf_mul(8'h09, a0) ^ gf_mul(8'h0e, a1) ^ gf_mul(8'h0b, a2) ^ gf_mul(8'h0d, a3);
      o[111-32*c -: 8] = gf_mul(8'h0d, a0) ^ gf_mul(8'h09, a1) ^ gf_mul(8'h0e, a2) ^ gf_mul(8'h0b, a3);
      o[103-32*c -: 8] = gf_mul(8'h0b, a0) ^ gf_mul(8'h0d, a1) ^ gf_mul(8'h09, a2) ^ gf_mul(8'h0e, a3);
    end
    inv_mix_columns = o;
  endfunction

  // ---------------- key schedule datapath ----------------
  logic [31:0]  kw0_s, kw1_s, kw2_s, kw3_s;
  logic [31:0]  bw1_s, bw2_s, bw3_s;
  logic [31:0]  sub_in_s, rot_s, sub_out_s;
  logic [31:0]  f0_s, f1_s, f2_s, f3_s, b0_s;
  logic [3:0]   rcon_idx_s;
  logic [31:0]  rcon_word_s;
  logic [127:0] key_fwd_s, key_back_s;

  assign kw0_s = key_q[127:96];
  assign kw1_s = key_q[95:64];
  assign kw2_s = key_q[63:32];
  assign kw3_s = key_q[31:0];

  // Backward step recovers w1..w3 of the previous round key first.
  assign bw3_s = kw3_s ^ kw2_s;
  assign bw2_s = kw2_s ^ kw1_s;
  assign bw1_s = kw1_s ^ kw0_s;

  // Counter to Rcon index: forward uses rk(i)'s own constant; backward from
  // rk(r+1) needs Rcon(r+1); FIN holds cnt=1 and steps rk1 -> rk0 with Rcon(1).
  always_comb begin
    rcon_idx_s = 4'd0;
    case (fsm_q)
      S_KEXP:  rcon_idx_s = cnt_q;
      S_DEC:   rcon_idx_s = cnt_q + 4'd1;
      S_FIN:   rcon_idx_s = cnt_q;
      default: rcon_idx_s = 4'd0;
    endcase
  end

  assign rcon_word_s = {rcon(rcon_idx_s), 24'h000000};

  // The four SubWord S-boxes are shared between forward and backward steps.
  assign sub_in_s = (fsm_q == S_KEXP) ? kw3_s : bw3_s;
  assign rot_s    = {sub_in_s[23:0], sub_in_s[31:24]};

  for (genvar i = 0; i < 4; i++) begin : g_subword
    sbox u_sbox (
      .a_i (rot_s[31-8*i -: 8]),
      .y_o (sub_out_s[31-8*i -: 8])
    );
  end

  assign f0_s      = kw0_s ^ sub_out_s ^ rcon_word_s;
  assign f1_s      = kw1_s ^ f0_s;
  assign f2_s      = kw2_s ^ f1_s;
  assign f3_s      = kw3_s ^ f2_s;
  assign key_fwd_s = {f0_s, f1_s, f2_s, f3_s};

  assign b0_s       = kw0_s ^ sub_out_s ^ rcon_word_s;
  assign key_back_s = {b0_s, bw1_s, bw2_s, bw3_s};

  // ---------------- round datapath ----------------
  logic [127:0] isr_s, isb_s, ark_s, imc_s;

  // InvShiftRows: row r rotates right by r, so out[r][c] = in[r][c-r].
  for (genvar c = 0; c < 4; c++) begin : g_isr_col
    for (genvar r = 0; r < 4; r++) begin : g_isr_row
      assign isr_s[127-8*(4*c+r) -: 8] = st_q[127-8*(4*((c-r+4)%4)+r) -: 8];
    end
  end

  for (genvar i = 0; i < 16; i++) begin : g_invsub
    inv_sbox u_inv_sbox (
      .a_i (isr_s[127-8*i -: 8]),
      .y_o (isb_s[127-8*i -: 8])
    );
  end

  // In DEC this is the round before InvMixColumns; in FIN it is the plaintext.
  assign ark_s = isb_s ^ key_back_s;
  assign imc_s = inv_mix_columns(ark_s);

  // Next-state and datapath register loads.
  always_comb begin
    fsm_d       = fsm_q;
    cnt_d       = cnt_q;
    key_d       = key_q;
    st_d        = st_q;
    pt_d        = pt_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    case (fsm_q)
      S_IDLE: begin
        if (in_valid && in_ready_q) begin
          key_d      = key_in;
          in_ready_d = 1'b0;
          if (KEY_IS_LAST) begin
            st_d  = cipher_in ^ key_in;
            cnt_d = 4'd9;
            fsm_d = S_DEC;
          end else begin
            st_d  = cipher_in;
            cnt_d = 4'd1;
            fsm_d = S_KEXP;
          end
        end else begin
          fsm_d = S_IDLE;
        end
      end
      S_KEXP: begin
        key_d = key_fwd_s;
        if (cnt_q == 4'd10) begin
          st_d  = st_q ^ key_fwd_s;
          cnt_d = 4'd9;
          fsm_d = S_DEC;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_DEC: begin
        key_d = key_back_s;
        st_d  = imc_s;
        if (cnt_q == 4'd1) begin
          fsm_d = S_FIN;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_FIN: begin
        key_d       = key_back_s;
        pt_d        = ark_s;
        out_valid_d = 1'b1;
        fsm_d       = S_HOLD;
      end
      S_HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          fsm_d       = S_IDLE;
        end else begin
          fsm_d = S_HOLD;
        end
      end
      default: begin
        fsm_d       = S_IDLE;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // State register with synchronous reset taking priority over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q       <= S_IDLE;
      cnt_q       <= 4'd0;
      key_q       <= 128'd0;
      st_q        <= 128'd0;
      pt_q        <= 128'd0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      fsm_q       <= fsm_d;
      cnt_q       <= cnt_d;
      key_q       <= key_d;
      st_q        <= st_d;
      pt_q        <= pt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign plain_out = pt_q;

endmodule

// ---------------------------------------------------------------------------
// sbox: forward AES S-box, GF inverse followed by the affine transform.
//   a_i in 8 input byte;  y_o out 8 substituted byte
// ---------------------------------------------------------------------------
module sbox
  import aes128_gf_pkg::*;
(
  input  logic [7:0] a_i,
  output logic [7:0] y_o
);
  logic [7:0] b_s;
  assign b_s = gf_inv(a_i);
  assign y_o = b_s ^ {b_s[6:0], b_s[7]} ^ {b_s[5:0], b_s[7:6]}
             ^ {b_s[4:0], b_s[7:5]} ^ {b_s[3:0], b_s[7:4]} ^ 8'h63;
endmodule

// ---------------------------------------------------------------------------
// inv_sbox: inverse AES S-box, inverse affine transform then GF inverse.
//   a_i in 8 input byte;  y_o out 8 substituted byte
// ---------------------------------------------------------------------------
module inv_sbox
  import aes128_gf_pkg::*;
(
  input  logic [7:0] a_i,
  output logic [7:0] y_o
);
  logic [7:0] t_s;
  assign t_s = {a_i[6:0], a_i[7]} ^ {a_i[4:0], a_i[7:5]} ^ {a_i[1:0], a_i[7:2]} ^ 8'h05;
  assign y_o = gf_inv(t_s);
endmodule

// File: tb/tb_aes128_decrypt_iter.sv
// ---------------------------------------------------------------------------
// tb_aes128_decrypt_iter
//   Self-checking bench for aes128_decrypt_iter. Instance 0 runs with
//   KEY_IS_LAST=0, instance 1 with KEY_IS_LAST=1. Expected plaintexts are
//   queued at each accept and popped when out_valid is seen.
// ---------------------------------------------------------------------------
module tb_aes128_decrypt_iter;

  localparam logic [127:0] K1   = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] P1   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] K2   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] C2   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] P2   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

  logic         clk;
  logic         rst;
  logic [1:0]   in_valid;
  logic [1:0]   in_ready;
  logic [1:0]   out_valid;
  logic [1:0]   out_ready;
  logic [127:0] cipher [2];
  logic [127:0] key    [2];
  logic [127:0] pout   [2];

  logic [127:0] exp_q [$];
  int           vectors;
  int           miscompares;

  aes128_decrypt_iter #(.KEY_IS_LAST(1'b0)) dut0 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid[0]),
    .in_ready  (in_ready[0]),
    .cipher_in (cipher[0]),
    .key_in    (key[0]),
    .out_valid (out_valid[0]),
    .out_ready (out_ready[0]),
    .plain_out (pout[0])
  );

  aes128_decrypt_iter #(.KEY_IS_LAST(1'b1)) dut1 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid[1]),
    .in_ready  (in_ready[1]),
    .cipher_in (cipher[1]),
    .key_in    (key[1]),
    .out_valid (out_valid[1]),
    .out_ready (out_ready[1]),
    .plain_out (pout[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge: present a block and return 1ns after the accept edge.
  task automatic send(input int d, input logic [127:0] c, input logic [127:0] k,
                      input logic [127:0] p, input bit keep);
    check("in_ready_before_accept", {127'd0, in_ready[d]}, 128'd1);
    in_valid[d] = 1'b1;
    cipher[d]   = c;
    key[d]      = k;
    @(posedge clk);
    exp_q.push_back(p);
    #1;
    if (!keep) in_valid[d] = 1'b0;
  endtask

  // Called just after the accept edge: wait for out_valid, check latency and data.
  task automatic wait_out(input int d, input int exp_lat, input string tag);
    int  lat;
    bit  found;
    logic [127:0] e;
    lat   = 0;
    found = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (out_valid[d]) begin
        found = 1'b1;
        lat   = i;
        break;
      end
    end
    check({tag, "_out_valid_seen"}, {127'd0, found}, 128'd1);
    check({tag, "_latency"}, 128'(lat), 128'(exp_lat));
    check({tag, "_queue_nonempty"}, {127'd0, (exp_q.size() > 0)}, 128'd1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check({tag, "_plain_out"}, pout[d], e);
    end
  endtask

  initial begin
    int ov_count;
    logic [127:0] snap;
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    in_valid    = 2'b00;
    out_ready   = 2'b11;
    for (int d = 0; d < 2; d++) begin
      cipher[d] = 128'd0;
      key[d]    = 128'd0;
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state of both instances.
    for (int d = 0; d < 2; d++) begin
      check("reset_in_ready", {127'd0, in_ready[d]}, 128'd1);
      check("reset_out_valid", {127'd0, out_valid[d]}, 128'd0);
      check("reset_plain_out", pout[d], 128'd0);
    end

    // Test 1: FIPS-197 C.1 vector, out_valid exactly one cycle.
    send(0, C1, K1, P1, 1'b0);
    wait_out(0, 20, "t1");
    @(negedge clk);
    check("t1_out_valid_one_cycle", {127'd0, out_valid[0]}, 128'd0);
    check("t1_in_ready_after", {127'd0, in_ready[0]}, 128'd1);

    // Test 2: FIPS-197 Appendix B vector.
    send(0, C2, K2, P2, 1'b0);
    wait_out(0, 20, "t2");
    @(negedge clk);
    check("t2_out_valid_one_cycle", {127'd0, out_valid[0]}, 128'd0);

    // Test 3: rk10 supplied directly.
    send(1, C2, RK10, P2, 1'b0);
    wait_out(1, 10, "t3");
    @(negedge clk);
    check("t3_out_valid_one_cycle", {127'd0, out_valid[1]}, 128'd0);
    check("t3_in_ready_after", {127'd0, in_ready[1]}, 128'd1);

    // Test 4: back-pressure with in_valid pulses during HOLD.
    out_ready[0] = 1'b0;
    send(0, C1, K1, P1, 1'b0);
    wait_out(0, 20, "t4");
    snap = pout[0];
    for (int i = 0; i < 7; i++) begin
      in_valid[0] = (i % 2 == 0);
      cipher[0]   = {$urandom, $urandom, $urandom, $urandom};
      key[0]      = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
      check("t4_plain_out_stable", pout[0], snap);
      check("t4_out_valid_held", {127'd0, out_valid[0]}, 128'd1);
      check("t4_in_ready_low", {127'd0, in_ready[0]}, 128'd0);
    end
    in_valid[0]  = 1'b0;
    out_ready[0] = 1'b1;
    @(negedge clk);
    check("t4_out_valid_cleared", {127'd0, out_valid[0]}, 128'd0);
    check("t4_in_ready_back", {127'd0, in_ready[0]}, 128'd1);
    ov_count = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (out_valid[0]) ov_count++;
    end
    check("t4_no_spurious_output", 128'(ov_count), 128'd0);
    check("t4_queue_empty", 128'(exp_q.size()), 128'd0);

    // Test 5: back-to-back with in_valid held high.
    send(0, C1, K1, P1, 1'b1);
    cipher[0] = C2;
    key[0]    = K2;
    wait_out(0, 20, "t5a");
    @(negedge clk);
    check("t5_in_ready_after_first", {127'd0, in_ready[0]}, 128'd1);
    check("t5_out_valid_after_first", {127'd0, out_valid[0]}, 128'd0);
    @(posedge clk);
    exp_q.push_back(P2);
    #1;
    in_valid[0] = 1'b0;
    wait_out(0, 20, "t5b");
    @(negedge clk);

    // Test 6: reset at accept+12, then a fresh block.
    send(0, C1, K1, P1, 1'b0);
    ov_count = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (out_valid[0]) ov_count++;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t6_reset_in_ready", {127'd0, in_ready[0]}, 128'd1);
    check("t6_reset_out_valid", {127'd0, out_valid[0]}, 128'd0);
    check("t6_reset_plain_out", pout[0], 128'd0);
    if (exp_q.size() > 0) void'(exp_q.pop_back());
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (out_valid[0]) ov_count++;
    end
    check("t6_no_output_after_reset", 128'(ov_count), 128'd0);
    send(0, C2, K2, P2, 1'b0);
    wait_out(0, 20, "t6");
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
